// File: rtl/mar.sv
// SAP-1 memory address register: captures the W-bus address on load and drives it to RAM.
// Optional MAR_PROG_MODE_EN adds a front-panel switch override on the address output.
module mar #(
    parameter int unsigned           WIDTH      = 4,
    parameter logic [WIDTH-1:0]      RESET_ADDR = '0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
`ifdef MAR_PROG_MODE_EN
    input  logic             prog,
    input  logic [WIDTH-1:0] SW,
`endif
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] addr_d;
    logic [WIDTH-1:0] addr_q;

    // Reset beats load; otherwise hold so Q is steady through non-T1 states.
    always_comb begin
        addr_d = addr_q;
        if (CLR) begin
            addr_d = RESET_ADDR;
        end else if (load) begin
            addr_d = D;
        end
    end

    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
    end

`ifdef MAR_PROG_MODE_EN
    // Switches act immediately; the register keeps running underneath.
    assign Q = prog ? SW : addr_q;
`else
    assign Q = addr_q;
`endif

endmodule

// File: tb/tb_mar.sv
// Scoreboard bench for mar: driver pushes expected Q per cycle, negedge monitor compares.
module tb_mar;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] val;
        string        name;
    } exp_t;

    logic         CLK;
    logic         CLR;
    logic [W-1:0] D;
    logic         load;
    logic [W-1:0] Q;
`ifdef MAR_PROG_MODE_EN
    logic         prog;
    logic [W-1:0] SW;
`endif

    exp_t         sb_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] model_addr;

    mar #(.WIDTH(W), .RESET_ADDR('0)) dut (
        .CLK  (CLK),
        .CLR  (CLR),
        .D    (D),
        .load (load),
`ifdef MAR_PROG_MODE_EN
        .prog (prog),
        .SW   (SW),
`endif
        .Q    (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: one expected value per clock, checked mid-cycle.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            if (Q !== e.val) begin
                bad++;
                $display("FAIL %s: got Q=%h expected %h at %0t", e.name, Q, e.val, $time);
            end
        end
    end

    // One clock: apply inputs after the monitor sample, advance reference on the edge.
    task automatic cyc(input logic c, input logic l, input logic [W-1:0] d,
                       input logic p, input logic [W-1:0] sw, input string name);
        exp_t e;
        @(negedge CLK);
        #1;
        CLR  = c;
        load = l;
        D    = d;
`ifdef MAR_PROG_MODE_EN
        prog = p;
        SW   = sw;
`endif
        @(posedge CLK);
        if (c)      model_addr = '0;
        else if (l) model_addr = d;
        e.name = name;
`ifdef MAR_PROG_MODE_EN
        e.val  = p ? sw : model_addr;
`else
        e.val  = model_addr;
`endif
        sb_q.push_back(e);
    endtask

    initial begin
        logic [W-1:0] cnt;
        CLR = 1'b0; load = 1'b0; D = '0;
`ifdef MAR_PROG_MODE_EN
        prog = 1'b0; SW = '0;
`endif
        model_addr = 'x;

        // Reset with a competing load, then idle
        cyc(1'b1, 1'b1, 4'hA, 1'b0, 4'h0, "reset");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, W'(i + 1), 1'b0, 4'h0, "reset_hold");

        // Single load then D free-runs with load low
        cyc(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, "single_load");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, W'(6 + i), 1'b0, 4'h0, "single_hold");

        // Multi-cycle load: last edge wins
        cyc(1'b0, 1'b1, 4'h3, 1'b0, 4'h0, "multi_load0");
        cyc(1'b0, 1'b1, 4'h4, 1'b0, 4'h0, "multi_load1");
        cyc(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, "multi_load2");
        cnt = 4'h6;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, cnt, 1'b0, 4'h0, "multi_hold");
            cnt = cnt + 4'h1;
        end

        // Code wrap is stored verbatim
        cyc(1'b0, 1'b1, 4'hE, 1'b0, 4'h0, "wrap_e");
        cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'h0, "wrap_f");
        cyc(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, "wrap_0");

        // Reset priority mid-load
        cyc(1'b0, 1'b1, 4'h6, 1'b0, 4'h0, "pre_rst_load");
        cyc(1'b1, 1'b1, 4'h9, 1'b0, 4'h0, "rst_mid_load");
        cyc(1'b0, 1'b1, 4'h9, 1'b0, 4'h0, "load_after_rst");

`ifdef MAR_PROG_MODE_EN
        cyc(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, "prog_setup");
        @(negedge CLK);
        #1;
        prog = 1'b1; SW = 4'hC;
        #1;
        total++;
        if (Q !== 4'hC) begin
            bad++;
            $display("FAIL prog_immediate: got Q=%h expected c", Q);
        end
        cyc(1'b0, 1'b1, 4'h2, 1'b1, 4'hC, "prog_load_hidden");
        cyc(1'b0, 1'b0, 4'h8, 1'b1, 4'hC, "prog_hold");
        cyc(1'b0, 1'b0, 4'h8, 1'b0, 4'hC, "prog_release");
`endif

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(15) == 0), $urandom_range(1) == 1, W'($urandom),
                ($urandom_range(3) == 0), W'($urandom), "random");
        end
`ifdef MAR_PROG_MODE_EN
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, "random_exit");
`endif

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge CLK);
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
